// File: rtl/stock_keeper.sv
// stock_keeper: per-lane goods inventory with admin replenish/clear/inquire
// and customer purchase. Optional SALES_LOG_EN adds per-lane sold counters.
// Ports: clk, rst (sync, active-high); admin: en, clear, re, re_lane,
//   re_amt, inquire, inq_lane; customer: buy, buy_lane;
//   results: stock_out, stock_vld, re_done, re_sat, buy_ok, buy_fail,
//   empty_mask, busy, sold_out.
module stock_keeper #(
  parameter int LANES     = 8,
  parameter int CNT_W     = 7,
  parameter int MAX_STOCK = 99
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             re,
  input  logic [2:0]       re_lane,
  input  logic [CNT_W-1:0] re_amt,
  input  logic             inquire,
  input  logic [2:0]       inq_lane,
  input  logic             buy,
  input  logic [2:0]       buy_lane,
  output logic [CNT_W-1:0] stock_out,
  output logic             stock_vld,
  output logic             re_done,
  output logic             re_sat,
  output logic             buy_ok,
  output logic             buy_fail,
  output logic [LANES-1:0] empty_mask,
  output logic             busy,
  output logic [7:0]       sold_out
);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  localparam logic [CNT_W:0]   L_MAXW = (CNT_W+1)'(MAX_STOCK);
  localparam logic [CNT_W-1:0] L_MAXC = CNT_W'(MAX_STOCK);
  localparam logic [2:0]       L_LAST = 3'(LANES-1);

  state_t           r_state;
  logic [2:0]       r_idx;
  logic [CNT_W-1:0] r_cnt [LANES];
  logic             r_clear_q;
  logic             r_re_q;
  logic             r_inq_q;
  logic             r_buy_q;

  logic             w_idle;
  logic             w_clr_e;
  logic             w_re_e;
  logic             w_inq_e;
  logic             w_buy_e;
  logic             w_clr_go;
  logic             w_re_go;
  logic             w_buy_go;
  logic             w_buy_ok;
  logic             w_buy_fail;
  logic             w_inq_go;
  logic [CNT_W:0]   w_sum;
  logic             w_sat;

  assign w_idle  = (r_state == S_IDLE);
  assign w_clr_e = clear & ~r_clear_q;
  assign w_re_e  = re & ~r_re_q;
  assign w_inq_e = inquire & ~r_inq_q;
  assign w_buy_e = buy & ~r_buy_q;

  // Priority: clear > re > buy > inquire; admin edges need en.
  assign w_clr_go = w_idle & w_clr_e & en;
  assign w_re_go  = w_idle & ~w_clr_go & w_re_e & en;
  assign w_buy_go = w_idle & w_buy_e
                  & ~(w_clr_e & en) & ~(w_re_e & en);
  assign w_inq_go = w_idle & w_inq_e & en & ~w_buy_e
                  & ~(w_clr_e & en) & ~(w_re_e & en);

  assign w_buy_ok   = w_buy_go & (r_cnt[buy_lane] != '0);
  // Any buy edge not vended (busy, lost priority, empty lane) is refused.
  assign w_buy_fail = w_buy_e & ~w_buy_ok;

  // One extra bit so the clip test sees the true sum.
  assign w_sum = {1'b0, r_cnt[re_lane]} + {1'b0, re_amt};
  assign w_sat = (w_sum > L_MAXW);

  always_comb begin
    empty_mask = '0;
    for (int i = 0; i < LANES; i++)
      empty_mask[i] = (r_cnt[i] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_clear_q <= 1'b0;
      r_re_q    <= 1'b0;
      r_inq_q   <= 1'b0;
      r_buy_q   <= 1'b0;
      stock_out <= '0;
      stock_vld <= 1'b0;
      re_done   <= 1'b0;
      re_sat    <= 1'b0;
      buy_ok    <= 1'b0;
      buy_fail  <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < LANES; i++)
        r_cnt[i] <= '0;
    end else begin
      r_clear_q <= clear;
      r_re_q    <= re;
      r_inq_q   <= inquire;
      r_buy_q   <= buy;
      stock_vld <= 1'b0;
      re_done   <= 1'b0;
      re_sat    <= 1'b0;
      buy_ok    <= w_buy_ok;
      buy_fail  <= w_buy_fail;
      case (r_state)
        S_IDLE: begin
          if (w_clr_go) begin
            r_state <= S_CLEAR;
            r_idx   <= '0;
            busy    <= 1'b1;
          end else if (w_re_go) begin
            r_cnt[re_lane] <= w_sat ? L_MAXC
                                    : w_sum[CNT_W-1:0];
            re_done <= 1'b1;
            re_sat  <= w_sat;
          end else if (w_buy_ok) begin
            r_cnt[buy_lane] <= r_cnt[buy_lane] - 1'b1;
          end else if (w_inq_go) begin
            stock_out <= r_cnt[inq_lane];
            stock_vld <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_cnt[r_idx] <= '0;
          r_idx        <= r_idx + 1'b1;
          if (r_idx == L_LAST) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef SALES_LOG_EN
  logic [7:0] r_sold [LANES];

  always_ff @(posedge clk) begin
    if (rst) begin
      sold_out <= '0;
      for (int i = 0; i < LANES; i++)
        r_sold[i] <= '0;
    end else begin
      if (r_state == S_CLEAR)
        r_sold[r_idx] <= '0;
      else if (w_buy_ok && r_sold[buy_lane] != 8'hFF)
        r_sold[buy_lane] <= r_sold[buy_lane] + 1'b1;
      if (w_inq_go)
        sold_out <= r_sold[inq_lane];
    end
  end
`else
  assign sold_out = '0;
`endif

endmodule

// File: tb/tb_stock_keeper.sv
// tb_stock_keeper: directed vector table plus hand sequences for
// held inputs, the clear sweep and reset abort.
module tb_stock_keeper;

`ifdef SALES_LOG_EN
  localparam bit SL = 1'b1;
`else
  localparam bit SL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en, clear, re, inquire, buy;
  logic [2:0] re_lane, inq_lane, buy_lane;
  logic [6:0] re_amt;
  logic [6:0] stock_out;
  logic       stock_vld, re_done, re_sat, buy_ok, buy_fail, busy;
  logic [7:0] empty_mask, sold_out;

  int checks = 0;
  int errors = 0;

  stock_keeper dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .re(re),
    .re_lane(re_lane), .re_amt(re_amt), .inquire(inquire),
    .inq_lane(inq_lane), .buy(buy), .buy_lane(buy_lane),
    .stock_out(stock_out), .stock_vld(stock_vld),
    .re_done(re_done), .re_sat(re_sat), .buy_ok(buy_ok),
    .buy_fail(buy_fail), .empty_mask(empty_mask),
    .busy(busy), .sold_out(sold_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       en, clr, re;
    logic [2:0] rl;
    logic [6:0] ra;
    logic       inq;
    logic [2:0] il;
    logic       buy;
    logic [2:0] bl;
    logic [6:0] so;
    logic       sv, rd, rs, bo, bf;
    logic [7:0] em;
    logic       bsy;
    logic [7:0] sl;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {3'b0, stock_out, stock_vld, re_done, re_sat, buy_ok,
            buy_fail, empty_mask, busy, sold_out};
  endfunction

  task automatic idle_in();
    clear = 0; re = 0; inquire = 0; buy = 0;
  endtask

  task automatic run_vec(input vec_t v);
    en = v.en; clear = v.clr; re = v.re; re_lane = v.rl;
    re_amt = v.ra; inquire = v.inq; inq_lane = v.il;
    buy = v.buy; buy_lane = v.bl;
    @(posedge clk); #1;
    chk(v.nm, outs(),
        {3'b0, v.so, v.sv, v.rd, v.rs, v.bo, v.bf, v.em, v.bsy,
         SL ? v.sl : 8'd0});
    idle_in();
    @(posedge clk); #1;
  endtask

  task automatic fill(input logic [2:0] l, input logic [6:0] a);
    en = 1; re = 1; re_lane = l; re_amt = a;
    @(posedge clk); #1;
    re = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    int nbo, nbf, nbusy;
    //         nm  en clr re rl ra inq il buy bl  so sv rd rs bo bf em bsy sl
    tv.push_back('{"re2_10",   1,0,1,2,10, 0,0, 0,0,  0,0,1,0,0,0,8'hFB,0,0});
    tv.push_back('{"inq2_10",  1,0,0,0,0,  1,2, 0,0, 10,1,0,0,0,0,8'hFB,0,0});
    tv.push_back('{"re2_85",   1,0,1,2,85, 0,0, 0,0, 10,0,1,0,0,0,8'hFB,0,0});
    tv.push_back('{"re2_sat",  1,0,1,2,10, 0,0, 0,0, 10,0,1,1,0,0,8'hFB,0,0});
    tv.push_back('{"re2_zero", 1,0,1,2,0,  0,0, 0,0, 10,0,1,0,0,0,8'hFB,0,0});
    tv.push_back('{"inq2_99",  1,0,0,0,0,  1,2, 0,0, 99,1,0,0,0,0,8'hFB,0,0});
    tv.push_back('{"re5_1",    1,0,1,5,1,  0,0, 0,0, 99,0,1,0,0,0,8'hDB,0,0});
    tv.push_back('{"buy5_ok",  1,0,0,0,0,  0,0, 1,5, 99,0,0,0,1,0,8'hFB,0,0});
    tv.push_back('{"buy5_fail",1,0,0,0,0,  0,0, 1,5, 99,0,0,0,0,1,8'hFB,0,0});
    tv.push_back('{"en0_re",   0,0,1,3,5,  0,0, 0,0, 99,0,0,0,0,0,8'hFB,0,0});
    tv.push_back('{"en0_inq",  0,0,0,0,0,  1,2, 0,0, 99,0,0,0,0,0,8'hFB,0,0});
    tv.push_back('{"en0_clr",  0,1,0,0,0,  0,0, 0,0, 99,0,0,0,0,0,8'hFB,0,0});
    tv.push_back('{"en0_buy2", 0,0,0,0,0,  0,0, 1,2, 99,0,0,0,1,0,8'hFB,0,0});
    tv.push_back('{"inq2_98",  1,0,0,0,0,  1,2, 0,0, 98,1,0,0,0,0,8'hFB,0,1});
    tv.push_back('{"re1_4",    1,0,1,1,4,  0,0, 0,0, 98,0,1,0,0,0,8'hF9,0,1});
    tv.push_back('{"re_buy1",  1,0,1,1,3,  0,0, 1,1, 98,0,1,0,0,1,8'hF9,0,1});
    tv.push_back('{"inq1_7",   1,0,0,0,0,  1,1, 0,0,  7,1,0,0,0,0,8'hF9,0,0});
    tv.push_back('{"re0_3",    1,0,1,0,3,  0,0, 0,0,  7,0,1,0,0,0,8'hF8,0,0});
    tv.push_back('{"buy0_a",   1,0,0,0,0,  0,0, 1,0,  7,0,0,0,1,0,8'hF8,0,0});
    tv.push_back('{"buy0_b",   1,0,0,0,0,  0,0, 1,0,  7,0,0,0,1,0,8'hF8,0,0});
    tv.push_back('{"buy0_c",   1,0,0,0,0,  0,0, 1,0,  7,0,0,0,1,0,8'hF9,0,0});
    tv.push_back('{"inq0_0",   1,0,0,0,0,  1,0, 0,0,  0,1,0,0,0,0,8'hF9,0,3});
    tv.push_back('{"buy_inq",  1,0,0,0,0,  1,0, 1,2,  0,0,0,0,1,0,8'hF9,0,3});
    tv.push_back('{"re_inq",   1,0,1,2,1,  1,1, 0,0,  0,0,1,0,0,0,8'hF9,0,3});
    tv.push_back('{"inq2_98b", 1,0,0,0,0,  1,2, 0,0, 98,1,0,0,0,0,8'hF9,0,2});

    rst = 1; en = 0; re_lane = 0; re_amt = 0; inq_lane = 0;
    buy_lane = 0; idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("reset", outs(), {3'b0, 7'd0, 5'b0, 8'hFF, 1'b0, 8'd0});
    rst = 0;
    @(posedge clk); #1;

    foreach (tv[i]) run_vec(tv[i]);

    // Buy held high: exactly one response.
    nbo = 0; nbf = 0;
    en = 1; buy = 1; buy_lane = 2;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      nbo += int'(buy_ok); nbf += int'(buy_fail);
    end
    buy = 0;
    @(posedge clk); #1;
    chk("held_buy", 32'({nbo[7:0], nbf[7:0]}), 32'h0100);
    run_vec('{"inq2_97", 1,0,0,0,0, 1,2, 0,0, 97,1,0,0,0,0,8'hF9,0,3});

    // Mid-run reset.
    rst = 1;
    @(posedge clk); #1;
    chk("reset2", outs(), {3'b0, 7'd0, 5'b0, 8'hFF, 1'b0, 8'd0});
    rst = 0;
    @(posedge clk); #1;

    // Clear sweep with en dropped, clear held, buy mid-sweep.
    for (int l = 0; l < 8; l++) fill(3'(l), 7'd7);
    chk("all_full", 32'(empty_mask), 32'h00);
    nbo = 0; nbf = 0; nbusy = 0;
    en = 1; clear = 1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      nbusy += int'(busy);
      nbo += int'(buy_ok); nbf += int'(buy_fail);
      if (c == 1) en = 0;
      if (c == 3) begin buy = 1; buy_lane = 7; end
      if (c == 5) buy = 0;
    end
    clear = 0;
    chk("sweep_busy", 32'(nbusy), 32'd8);
    chk("sweep_buy", 32'({nbo[7:0], nbf[7:0]}), 32'h0001);
    chk("sweep_empty", 32'(empty_mask), 32'hFF);

    // Reset aborts a sweep.
    fill(3, 7); fill(6, 7);
    chk("abort_pre", 32'(empty_mask), 32'hB7);
    en = 1; clear = 1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    chk("abort_busy", 32'(busy), 32'd1);
    rst = 1; clear = 0;
    @(posedge clk); #1;
    chk("abort_rst", 32'({busy, empty_mask}), 32'h0FF);
    rst = 0;
    nbusy = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      nbusy += int'(busy);
    end
    chk("abort_idle", 32'(nbusy), 32'd0);
    run_vec('{"post_re4", 1,0,1,4,2, 0,0, 0,0, 0,0,1,0,0,0,8'hEF,0,0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
